gpo_blink: RTL and testbench

Parametrised general-purpose output core for the MMIO slot bus, successor to the basic single-register output core. Holds a W-bit output register with atomic set/clear/toggle write ports, read-back of all state, and an optional per-bit hardware blink engine driven by a programmable half-period counter. Sits in one slot of the MMIO subsystem; `data_out` drives LEDs or other external pins.

---
 rtl/gpo_blink.sv | 162 ++++++++++++++++
 tb/tb_gpo_blink.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpo_blink.sv
// -----------------------------------------------------------------------------
// gpo_blink
//
// General-purpose output core for one slot of the MMIO bus. Holds a W-bit
// output register with atomic DATA/SET/CLR/TGL write ports and read-back.
// Defining GPO_BLINK_EN adds a per-bit hardware blink engine: a BLINK_MASK
// register, a programmable half-period counter (PERIOD) and a STATUS register
// exposing the blink phase. Without GPO_BLINK_EN, addresses 4..6 behave as
// unmapped and data_out is the plain output register.
//
// Register map (addr):
//   0 DATA  R/W   1 SET WO   2 CLR WO   3 TGL WO
//   4 BLINK_MASK R/W   5 PERIOD R/W   6 STATUS RO (bit0 = phase)
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   cs        in   slot chip select
//   read      in   read strobe (qualified by cs)
//   write     in   write strobe (qualified by cs)
//   addr      in   5-bit register index
//   wr_data   in   32-bit write data (upper bits beyond register width ignored)
//   rd_data   out  32-bit combinational read data, zero-extended, 0 when idle
//   data_out  out  W-bit external output
// -----------------------------------------------------------------------------
module gpo_blink #(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          read,
    input  logic          write,
    input  logic [4:0]    addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    output logic [W-1:0]  data_out
);

    localparam logic [4:0] A_DATA   = 5'd0;
    localparam logic [4:0] A_SET    = 5'd1;
    localparam logic [4:0] A_CLR    = 5'd2;
    localparam logic [4:0] A_TGL    = 5'd3;
`ifdef GPO_BLINK_EN
    localparam logic [4:0] A_MASK   = 5'd4;
    localparam logic [4:0] A_PERIOD = 5'd5;
    localparam logic [4:0] A_STATUS = 5'd6;
`endif

    logic          wr_en;
    logic          rd_en;
    logic [W-1:0]  out_q;
    logic [W-1:0]  out_d;

    // Bits of wr_data above the register widths are intentionally ignored.
    logic          unused_wr_data;
    assign unused_wr_data = ^wr_data;

    assign wr_en = cs && write;
    assign rd_en = cs && read;

    // Output register with atomic set/clear/toggle ports.
    always_comb begin
        out_d = out_q;
        if (wr_en) begin
            case (addr)
                A_DATA:  out_d = wr_data[W-1:0];
                A_SET:   out_d = out_q | wr_data[W-1:0];
                A_CLR:   out_d = out_q & ~wr_data[W-1:0];
                A_TGL:   out_d = out_q ^ wr_data[W-1:0];
                default: out_d = out_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

`ifdef GPO_BLINK_EN
    logic [W-1:0]   mask_q;
    logic [W-1:0]   mask_d;
    logic [CW-1:0]  period_q;
    logic [CW-1:0]  period_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic           phase_q;
    logic           phase_d;

    always_comb begin
        mask_d   = mask_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;

        if (wr_en && (addr == A_MASK)) begin
            mask_d = wr_data[W-1:0];
        end

        // A PERIOD write restarts the engine from a clean phase so an old
        // count larger than the new period can never run past the wrap point.
        if (wr_en && (addr == A_PERIOD)) begin
            period_d = wr_data[CW-1:0];
            cnt_d    = '0;
            phase_d  = 1'b0;
        end else if (period_q == '0) begin
            cnt_d    = '0;
            phase_d  = 1'b0;
        end else if (cnt_q == (period_q - CW'(1))) begin
            cnt_d    = '0;
            phase_d  = ~phase_q;
        end else begin
            cnt_d    = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q   <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    // Blinking bits show buf inverted during the odd half-period.
    assign data_out = out_q ^ (mask_q & {W{phase_q}});

    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            case (addr)
                A_DATA:   rd_data[W-1:0]  = out_q;
                A_MASK:   rd_data[W-1:0]  = mask_q;
                A_PERIOD: rd_data[CW-1:0] = period_q;
                A_STATUS: rd_data[0]      = phase_q;
                default:  rd_data         = '0;
            endcase
        end
    end
`else
    assign data_out = out_q;

    always_comb begin
        rd_data = '0;
        if (rd_en && (addr == A_DATA)) begin
            rd_data[W-1:0] = out_q;
        end
    end
`endif

endmodule

// File: tb/tb_gpo_blink.sv
// -----------------------------------------------------------------------------
// tb_gpo_blink
//
// Scoreboard bench for gpo_blink. The driver issues one bus cycle per clock
// shortly after the rising edge and pushes the expected data_out / rd_data for
// that cycle; a monitor pops and compares on the falling edge. The reference
// model keeps the architectural registers and derives the blink phase from the
// number of edges elapsed since PERIOD was last written.
// -----------------------------------------------------------------------------
module tb_gpo_blink;

    localparam int W  = 8;
    localparam int CW = 8;

    logic          clk;
    logic          reset;
    logic          cs;
    logic          read;
    logic          write;
    logic [4:0]    addr;
    logic [31:0]   wr_data;
    logic [31:0]   rd_data;
    logic [W-1:0]  data_out;

    gpo_blink #(.W(W), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .read     (read),
        .write    (write),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] dout;
        logic [31:0]  rd;
        int           id;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc_id = 0;

    // Reference model state.
    logic [W-1:0] m_buf;
    logic [W-1:0] m_mask;
    int unsigned  m_period;
    int unsigned  m_t;       // edges since the last PERIOD write

    function automatic logic m_phase();
        if (m_period == 0) return 1'b0;
        return ((m_t / m_period) % 2) == 1;
    endfunction

    function automatic logic [W-1:0] m_dout();
`ifdef GPO_BLINK_EN
        return m_buf ^ (m_mask & {W{m_phase()}});
`else
        return m_buf;
`endif
    endfunction

    function automatic logic [31:0] m_read(input logic c, input logic r, input logic [4:0] a);
        logic [31:0] v;
        v = 32'h0;
        if (c && r) begin
            if (a == 5'd0) v = 32'(m_buf);
`ifdef GPO_BLINK_EN
            if (a == 5'd4) v = 32'(m_mask);
            if (a == 5'd5) v = m_period;
            if (a == 5'd6) v = {31'h0, m_phase()};
`endif
        end
        return v;
    endfunction

    task automatic m_reset();
        m_buf    = '0;
        m_mask   = '0;
        m_period = 0;
        m_t      = 0;
    endtask

    task automatic m_step(input logic c, input logic w, input logic [4:0] a, input logic [31:0] d);
        bit pw;
        pw = 1'b0;
        if (c && w) begin
            case (a)
                5'd0: m_buf = d[W-1:0];
                5'd1: m_buf = m_buf | d[W-1:0];
                5'd2: m_buf = m_buf & ~d[W-1:0];
                5'd3: m_buf = m_buf ^ d[W-1:0];
`ifdef GPO_BLINK_EN
                5'd4: m_mask = d[W-1:0];
                5'd5: begin
                    m_period = int'(d[CW-1:0]);
                    pw = 1'b1;
                end
`endif
                default: ;
            endcase
        end
        if (pw) m_t = 0;
        else    m_t = m_t + 1;
    endtask

    // One bus cycle: drive just after the rising edge, record expectation,
    // then advance the model to the state after the next rising edge.
    task automatic bus(input logic rst_v, input logic c, input logic r, input logic w,
                       input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        @(posedge clk);
        #1;
        reset   = rst_v;
        cs      = c;
        read    = r;
        write   = w;
        addr    = a;
        wr_data = d;
        if (!rst_v) m_reset();
        e.dout = m_dout();
        e.rd   = m_read(c, r, a);
        e.id   = cyc_id;
        cyc_id++;
        q.push_back(e);
        if (rst_v) m_step(c, w, a, d);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus(1'b1, 1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [4:0] a);
        bus(1'b1, 1'b1, 1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    // Monitor: compare DUT outputs against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (data_out !== e.dout) begin
                    fails++;
                    $display("FAIL data_out cyc=%0d got=%h exp=%h", e.id, data_out, e.dout);
                end
                tests++;
                if (rd_data !== e.rd) begin
                    fails++;
                    $display("FAIL rd_data cyc=%0d addr=%0d got=%h exp=%h", e.id, addr, rd_data, e.rd);
                end
            end
        end
    end

    initial begin
        logic [4:0]  a;
        logic [31:0] d;
        logic        c, r, w, rs;

        reset   = 1'b0;
        cs      = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = '0;
        wr_data = '0;
        m_reset();

        // Reset held, reads of every register return 0.
        for (int i = 0; i < 8; i++) bus(1'b0, 1'b1, 1'b1, 1'b0, 5'(i), 32'h0);
        idle(2);

        // DATA write and read-back.
        wr(5'd0, 32'hFFFF_FFA5);
        rd(5'd0);

        // Atomic set/clear/toggle and WO read-back.
        wr(5'd0, 32'hF0);
        wr(5'd1, 32'h03);
        wr(5'd2, 32'h80);
        wr(5'd3, 32'hFF);
        rd(5'd1);
        rd(5'd2);
        rd(5'd3);
        rd(5'd0);

        // Blink bit0 with half-period 3.
        wr(5'd0, 32'h00);
        wr(5'd4, 32'h01);
        wr(5'd5, 32'd3);
        for (int i = 0; i < 14; i++) rd(5'd6);
        rd(5'd4);
        rd(5'd5);

        // Shorten the period mid-count.
        wr(5'd5, 32'd10);
        idle(7);
        wr(5'd5, 32'd4);
        for (int i = 0; i < 12; i++) rd(5'd6);

        // SET/CLR/TGL on a blinking bit.
        wr(5'd1, 32'h01);
        idle(3);
        wr(5'd3, 32'h0F);
        idle(3);

        // Asynchronous reset mid-blink, then engine stays off.
        idle(2);
        bus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        rd(5'd5);
        rd(5'd4);
        rd(5'd6);
        idle(5);

        // Unmapped / optional addresses.
        wr(5'd0, 32'h3C);
        wr(5'd4, 32'hFF);
        wr(5'd5, 32'hFF);
        wr(5'd9, 32'hFF);
        rd(5'd4);
        rd(5'd5);
        rd(5'd9);
        rd(5'd31);
        rd(5'd0);

        // Maximum period: toggles after 255 and 510 edges.
        wr(5'd4, 32'hFF);
        wr(5'd5, 32'hFF);
        idle(515);
        wr(5'd5, 32'h0);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            a  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
            d  = $urandom;
            if (a == 5'd5) d = 32'($urandom_range(0, 6));
            c  = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 1) == 1;
            w  = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 99) != 0);
            bus(rs, c, r, w, a, d);
        end

        idle(2);
        repeat (2) @(posedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
